fpu_feeder: RTL
===============

FPU_FEEDER -- requirements
Module: fpu_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand-pair FIFO depth (power of 2, >=2).
REQ-002 SHALL have port clock  input  1  sole clock, all flops on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports in_valid/in_ready  input/output  1/1  operand-pair handshake.
REQ-005 SHALL have ports in_op_a/in_op_b  input  32/32  operands (1 sign, 6 exp bias 31, 25 mantissa).
REQ-006 SHALL have ports fpu_op_a/fpu_op_b/fpu_calc  output  32/32/1  drive the downstream FPU operands and calc.
REQ-007 SHALL have ports fpu_data/fpu_state  input  32/State_e  FPU result and status.
REQ-008 SHALL have ports out_valid/out_ready  output/input  1/1  result handshake.
REQ-009 SHALL have ports out_data/out_state  output  32/State_e  captured result and status.
REQ-010 SHALL have ports sticky_flags  output  3  {OVERFLOW, UNDERFLOW, INEXACT} seen since clear; clear_sticky  input  1  clears them.
REQ-011 SHALL have ports fifo_count  output  $clog2(DEPTH)+1  FIFO occupancy; busy  output  1  state != IDLE.

Function
REQ-012 SHALL push in_op_a/in_op_b into the FIFO on clock edges where in_valid && in_ready; in_ready = !full, independent of same-cycle pops.
REQ-013 SHALL run the FSM IDLE -> ISSUE -> WAIT -> HOLD.
REQ-014 In IDLE with FIFO non-empty, SHALL pop the head, register it onto fpu_op_a/fpu_op_b with fpu_calc=1, and go to ISSUE.
REQ-015 In ISSUE (fpu_calc high exactly one cycle), SHALL deassert fpu_calc at the next edge and go to WAIT.
REQ-016 In WAIT, SHALL capture fpu_data/fpu_state into out_data/out_state, set out_valid, and go to HOLD; the FPU result is valid one cycle after calc is sampled.
REQ-017 In HOLD, SHALL keep out_data/out_state stable while out_valid && !out_ready.
REQ-018 In HOLD with out_ready: SHALL clear out_valid; if the FIFO is non-empty, pop the head and go to ISSUE in the same edge, else go to IDLE.
REQ-019 fpu_op_a/fpu_op_b SHALL hold the last issued values outside ISSUE.
REQ-020 On capture, SHALL set the sticky bit matching fpu_state (EXACT sets none); clear_sticky in the same cycle as a capture SHALL clear the other bits, and the captured event's bit SHALL be set.
REQ-021 A simultaneous push and pop SHALL leave fifo_count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 An empty FIFO SHALL never pop; a full FIFO SHALL never push.
REQ-023 Sustained throughput SHALL be one result per 3 cycles when out_ready stays high.

Reset
REQ-024 Reset low SHALL immediately force: FSM IDLE, FIFO empty, fifo_count 0, in_ready 1 (after deassertion), fpu_calc 0, fpu_op_a/fpu_op_b 0, out_valid 0, out_data 0, out_state EXACT, sticky_flags 0, busy 0.
REQ-025 Reset asserted mid-operation (ISSUE/WAIT/HOLD) SHALL discard the in-flight result and all queued pairs with no output handshake.

Structure
REQ-026 State_e (EXACT, INEXACT, OVERFLOW, UNDERFLOW) and the new Feeder_state_e (IDLE, ISSUE, WAIT, HOLD) SHALL live in package States.
REQ-027 Sticky-bit index constants SHALL live in States.
REQ-028 The FIFO SHALL be sub-module fpu_feeder_fifo (parameter DEPTH, width 64, push/pop/full/empty/count).

Verification
REQ-029 Push A=0x3E000000, B=0x3E000000 (1.0+1.0) with out_ready=1 -> fpu_calc pulses for 1 cycle, out_valid 2 cycles later with out_data=0x40000000 and out_state=EXACT, sticky=000.
REQ-030 Push A=B=0x7FFFFFFF -> out_data=0x7E000000, out_state=OVERFLOW, sticky_flags[OVERFLOW]=1 until clear_sticky.
REQ-031 With DEPTH=4 and out_ready=0, offer 6 pairs -> 5 accepted (1 held in output, 4 queued), in_ready=0 and fifo_count=4; then raise out_ready -> 5 results in order, each 3 cycles apart.
REQ-032 Hold out_ready=0 for 10 cycles in HOLD -> out_data/out_state constant, no further fpu_calc pulses.
REQ-033 Assert reset during WAIT -> out_valid, fpu_calc, fifo_count read 0 before the next clock edge, and no result is emitted after reset release.
REQ-034 Assert clear_sticky in the same cycle as an INEXACT capture, with OVERFLOW previously set -> sticky_flags=001 (INEXACT only).

Source files
------------

// File: rtl/fpu_feeder_pkg.sv
// Shared types for the FPU feeder: FPU status, feeder FSM states, sticky-bit
// layout and the operand-pair payload carried through the FIFO.
package States;

    localparam int unsigned OP_W     = 32;
    localparam int unsigned STICKY_W = 3;

    // Sticky flag bit positions: {OVERFLOW, UNDERFLOW, INEXACT}
    localparam int unsigned STICKY_INEXACT   = 0;
    localparam int unsigned STICKY_UNDERFLOW = 1;
    localparam int unsigned STICKY_OVERFLOW  = 2;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } State_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } Feeder_state_e;

    typedef struct packed {
        logic [OP_W-1:0] op_a;
        logic [OP_W-1:0] op_b;
    } op_pair_t;

    localparam int unsigned PAIR_W = $bits(op_pair_t);

    // Map an FPU status onto its sticky bit; EXACT raises nothing
    function automatic logic [STICKY_W-1:0] sticky_event(input State_e s);
        sticky_event = '0;
        case (s)
            INEXACT:   sticky_event[STICKY_INEXACT]   = 1'b1;
            UNDERFLOW: sticky_event[STICKY_UNDERFLOW] = 1'b1;
            OVERFLOW:  sticky_event[STICKY_OVERFLOW]  = 1'b1;
            default:   sticky_event = '0;
        endcase
    endfunction

endpackage

// File: rtl/fpu_feeder_fifo.sv
// Operand-pair FIFO for the FPU feeder.
// Ports: clock/reset (async active-low), push/push_data, pop/pop_data (head,
// valid while !empty), full, empty, count (occupancy 0..DEPTH).
// Pushes while full and pops while empty are ignored.
module fpu_feeder_fifo
    import States::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = PAIR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fpu_feeder.sv
// Feeds queued operand pairs to a single-issue FPU and returns its results.
// Ports: clock, reset (async active-low); in_valid/in_ready/in_op_a/in_op_b
// operand-pair input; fpu_op_a/fpu_op_b/fpu_calc to the FPU, fpu_data/
// fpu_state back from it; out_valid/out_ready/out_data/out_state result
// output; sticky_flags/clear_sticky accumulated status; fifo_count, busy.
// One pair is in flight at a time: IDLE -> ISSUE -> WAIT -> HOLD, with HOLD
// chaining straight into ISSUE for one result every three cycles.
module fpu_feeder
    import States::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OP_W-1:0]        in_op_a,
    input  logic [OP_W-1:0]        in_op_b,
    output logic [OP_W-1:0]        fpu_op_a,
    output logic [OP_W-1:0]        fpu_op_b,
    output logic                   fpu_calc,
    input  logic [OP_W-1:0]        fpu_data,
    input  State_e                 fpu_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OP_W-1:0]        out_data,
    output State_e                 out_state,
    output logic [STICKY_W-1:0]    sticky_flags,
    input  logic                   clear_sticky,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy
);

    Feeder_state_e state;
    op_pair_t      push_pair;
    logic [PAIR_W-1:0] head_raw;
    op_pair_t      head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    assign push_pair = '{op_a: in_op_a, op_b: in_op_b};
    assign head      = op_pair_t'(head_raw);
    assign in_ready  = !fifo_full;

    // Dequeue whenever the FSM is about to issue a new pair
    assign pop = !fifo_empty && ((state == IDLE) || ((state == HOLD) && out_ready));

    fpu_feeder_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (in_valid),
        .push_data (push_pair),
        .pop       (pop),
        .pop_data  (head_raw),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue/capture FSM; all FPU-facing and result outputs are registered here
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            fpu_calc     <= 1'b0;
            fpu_op_a     <= '0;
            fpu_op_b     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_state    <= EXACT;
            sticky_flags <= '0;
        end else begin
            // Capture below overrides this so the new event survives a clear
            if (clear_sticky) sticky_flags <= '0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        fpu_op_a <= head.op_a;
                        fpu_op_b <= head.op_b;
                        fpu_calc <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    fpu_calc <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: begin
                    out_data     <= fpu_data;
                    out_state    <= fpu_state;
                    out_valid    <= 1'b1;
                    sticky_flags <= (clear_sticky ? '0 : sticky_flags)
                                    | sticky_event(fpu_state);
                    state        <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            fpu_op_a <= head.op_a;
                            fpu_op_b <= head.op_b;
                            fpu_calc <= 1'b1;
                            state    <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
